mc_id_stage: RTL

MC_ID_STAGE -- requirements
Module: mc_id_stage

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_scoreboard.sv | 33 +++
 rtl/mc_id_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared decode constants, FSM state type and operand bundle for the MIPS-style ID stage.
package mc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREGS = 32;
    localparam int unsigned OP_W  = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_HOLD
    } id_state_e;

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] dst;
        logic             wen;
    } ex_bundle_t;

    function automatic logic uses_rs(input logic [OP_W-1:0] op);
        return !(op == OP_J || op == OP_JAL);
    endfunction

    function automatic logic uses_rt(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
    function automatic logic [XLEN-1:0] ext_imm(input logic [OP_W-1:0] op,
                                                input logic [15:0]     imm16);
        if (op inside {[OP_ANDI:OP_XORI]})
            return {16'h0000, imm16};
        return {{16{imm16[15]}}, imm16};
    endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Register busy mask: one bit per GPR, set on issue and cleared on writeback.
module mc_scoreboard
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_nxt;

    // Set is applied after clear so it wins on a collision; $zero never goes busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_idx] = 1'b0;
        if (set_en)
            busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/mc_id_stage.sv
// Decode/operand-read stage with RAW scoreboard interlock.
// Define MC_ID_BYPASS_EN to forward writeback data straight into READ.
module mc_id_stage
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc4,
    output logic [REG_W-1:0] rf_rs,
    output logic [REG_W-1:0] rf_rt,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_dst,
    output logic             ex_wen,
    output logic [OP_W-1:0]  ex_op,
    output logic [OP_W-1:0]  ex_funct,
    output logic [XLEN-1:0]  ex_pc4
);

    id_state_e        state;
    logic [XLEN-1:0]  ir;
    logic [XLEN-1:0]  pc4;
    ex_bundle_t       bnd;
    ex_bundle_t       dec;
    logic [NREGS-1:0] busy;
    logic [OP_W-1:0]  op;
    logic [OP_W-1:0]  fn;
    logic             rs_used;
    logic             rt_used;
    logic             byp_rs;
    logic             byp_rt;
    logic             hazard;
    logic             sb_set;

    assign rf_rs    = ir[25:21];
    assign rf_rt    = ir[20:16];
    assign op       = ir[31:26];
    assign fn       = ir[5:0];
    assign ex_op    = op;
    assign ex_funct = fn;
    assign ex_pc4   = pc4;
    assign ex_a     = bnd.a;
    assign ex_b     = bnd.b;
    assign ex_imm   = bnd.imm;
    assign ex_dst   = bnd.dst;
    assign ex_wen   = bnd.wen;

    assign rs_used = uses_rs(op);
    assign rt_used = uses_rt(op);

`ifdef MC_ID_BYPASS_EN
    assign byp_rs = wb_we && (wb_rd != '0) && (wb_rd == rf_rs) && rs_used;
    assign byp_rt = wb_we && (wb_rd != '0) && (wb_rd == rf_rt) && rt_used;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    assign hazard = (rs_used && busy[rf_rs] && !byp_rs) ||
                    (rt_used && busy[rf_rt] && !byp_rt);

    // Operand bundle as it would be latched if READ completes this cycle.
    always_comb begin
        dec     = '0;
        dec.imm = ext_imm(op, ir[15:0]);
`ifdef MC_ID_BYPASS_EN
        dec.a   = byp_rs ? wb_data : rf_data1;
        dec.b   = byp_rt ? wb_data : rf_data2;
`else
        dec.a   = rf_data1;
        dec.b   = rf_data2;
`endif
        if (op == OP_RTYPE) begin
            dec.dst = ir[15:11];
            dec.wen = (fn != FN_JR);
        end else if (op == OP_JAL) begin
            dec.dst = REG_RA;
            dec.wen = 1'b1;
        end else if ((op inside {[OP_ADDI:OP_LUI]}) || (op == OP_LW)) begin
            dec.dst = ir[20:16];
            dec.wen = 1'b1;
        end
    end

    assign sb_set = (state == ST_HOLD) && ex_ready && bnd.wen && (bnd.dst != '0);

    mc_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (sb_set),
        .set_idx (bnd.dst),
        .clr_en  (wb_we),
        .clr_idx (wb_rd),
        .busy    (busy)
    );

    // IDLE accepts, READ waits out hazards, HOLD presents to execute.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ir       <= '0;
            pc4      <= '0;
            bnd      <= '0;
            if_ready <= 1'b1;
            ex_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_valid) begin
                        ir       <= if_instr;
                        pc4      <= if_pc4;
                        if_ready <= 1'b0;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!hazard) begin
                        bnd      <= dec;
                        ex_valid <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ex_ready) begin
                        ex_valid <= 1'b0;
                        if_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    ex_valid <= 1'b0;
                    if_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
